// File: rtl/ps2_host_tx_if.sv
// Host-side PS/2 transmitter bus: byte handshake, raw pin samples,
// open-drain pin drives and transfer status.
`timescale 1ns/1ps
interface ps2_host_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_out;
    logic       ps2_dat_out;
    logic       busy;
    logic       done;
    logic [1:0] error;

    // Byte source and pin environment
    modport master (
        output tx_valid, tx_data, ps2_clk_in, ps2_dat_in,
        input  tx_ready, ps2_clk_out, ps2_dat_out, busy, done, error
    );

    // The transmitter itself
    modport slave (
        input  tx_valid, tx_data, ps2_clk_in, ps2_dat_in,
        output tx_ready, ps2_clk_out, ps2_dat_out, busy, done, error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Inhibits the bus, issues the
// request-to-send, shifts out data/parity/stop on device falling edges,
// checks the device ACK and waits for the bus to go idle again.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | lines released, ready for a byte
// INHIBIT | clock held low, data released
// REQ     | clock and data low (start bit / request-to-send)
// BITS    | clock released, data/parity/stop on device falling edges
// ACK     | waiting for the device ACK falling edge
// RELEASE | waiting for both lines high
// DONE    | one-cycle done pulse, error valid
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int CLK_FREQ         = 28_000_000,
    parameter int INHIBIT_US       = 100,
    parameter int FIRST_TIMEOUT_US = 15000,
    parameter int BIT_TIMEOUT_US   = 2000
) (
    input  logic          clk28,
    input  logic          rst,
    ps2_host_tx_if.slave  bus
);

    // Products of microseconds and Hz overflow 32 bits, so scale in 64.
    localparam int INHIBIT_CYC = int'(longint'(INHIBIT_US) * longint'(CLK_FREQ) / 64'd1_000_000);
    localparam int REQ_CYC     = CLK_FREQ / 200_000;
    localparam int FIRST_CYC   = int'(longint'(FIRST_TIMEOUT_US) * longint'(CLK_FREQ) / 64'd1_000_000);
    localparam int BIT_CYC     = int'(longint'(BIT_TIMEOUT_US) * longint'(CLK_FREQ) / 64'd1_000_000);
    localparam int MAX_A       = (INHIBIT_CYC > REQ_CYC) ? INHIBIT_CYC : REQ_CYC;
    localparam int MAX_B       = (FIRST_CYC > BIT_CYC) ? FIRST_CYC : BIT_CYC;
    localparam int MAX_LOAD    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW          = $clog2(MAX_LOAD + 1);

    // The timer is loaded with N-1 so a phase lasts exactly N cycles.
    localparam logic [TW-1:0] INHIBIT_LD = TW'(INHIBIT_CYC - 1);
    localparam logic [TW-1:0] REQ_LD     = TW'(REQ_CYC - 1);
    localparam logic [TW-1:0] FIRST_LD   = TW'(FIRST_CYC - 1);
    localparam logic [TW-1:0] BIT_LD     = TW'(BIT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_BITS, S_ACK, S_RELEASE, S_DONE
    } state_t;

    state_t          state, state_n;
    logic [TW-1:0]   tmr, tmr_n;
    logic [3:0]      bit_cnt, bit_cnt_n;
    logic [7:0]      data, data_n;
    logic            parity, parity_n;
    logic            dat_reg, dat_reg_n;
    logic            nack, nack_n;
    logic [1:0]      error_q, error_n;
    logic            clk_s1, clk_s2, clk_prev;
    logic            dat_s1, dat_s2;
    logic            ready_en;

    logic            fall;
    logic            tmr_zero;
    logic [TW-1:0]   tmr_dec;

    assign fall     = clk_prev & ~clk_s2;
    assign tmr_zero = (tmr == '0);
    assign tmr_dec  = tmr_zero ? tmr : tmr - TW'(1);

    // Pin synchronizers; reset to the idle-high level so no false edge appears.
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= bus.ps2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= bus.ps2_dat_in;
            dat_s2   <= dat_s1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            tmr      <= '0;
            bit_cnt  <= '0;
            data     <= '0;
            parity   <= 1'b0;
            dat_reg  <= 1'b1;
            nack     <= 1'b0;
            error_q  <= 2'b00;
            ready_en <= 1'b0;
        end else begin
            state    <= state_n;
            tmr      <= tmr_n;
            bit_cnt  <= bit_cnt_n;
            data     <= data_n;
            parity   <= parity_n;
            dat_reg  <= dat_reg_n;
            nack     <= nack_n;
            error_q  <= error_n;
            ready_en <= 1'b1;
        end
    end

    // Next-state and datapath updates; timer expiry beats a same-cycle edge.
    always_comb begin
        state_n   = state;
        tmr_n     = tmr_dec;
        bit_cnt_n = bit_cnt;
        data_n    = data;
        parity_n  = parity;
        dat_reg_n = dat_reg;
        nack_n    = nack;
        error_n   = error_q;
        case (state)
            S_IDLE: begin
                tmr_n = '0;
                if (bus.tx_valid && ready_en) begin
                    data_n    = bus.tx_data;
                    parity_n  = ~^bus.tx_data;
                    bit_cnt_n = '0;
                    nack_n    = 1'b0;
                    tmr_n     = INHIBIT_LD;
                    state_n   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (tmr_zero) begin
                    tmr_n   = REQ_LD;
                    state_n = S_REQ;
                end
            end
            S_REQ: begin
                if (tmr_zero) begin
                    tmr_n     = FIRST_LD;
                    dat_reg_n = 1'b0;
                    state_n   = S_BITS;
                end
            end
            S_BITS: begin
                if (tmr_zero) begin
                    error_n = 2'b10;
                    state_n = S_DONE;
                end else if (fall) begin
                    tmr_n     = BIT_LD;
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt < 4'd8)
                        dat_reg_n = data[bit_cnt[2:0]];
                    else if (bit_cnt == 4'd8)
                        dat_reg_n = parity;
                    else
                        dat_reg_n = 1'b1;
                    if (bit_cnt == 4'd9)
                        state_n = S_ACK;
                end
            end
            S_ACK: begin
                if (tmr_zero) begin
                    error_n = 2'b10;
                    state_n = S_DONE;
                end else if (fall) begin
                    tmr_n   = BIT_LD;
                    nack_n  = dat_s2;
                    state_n = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (tmr_zero) begin
                    error_n = 2'b10;
                    state_n = S_DONE;
                end else if (clk_s2 && dat_s2) begin
                    error_n = nack ? 2'b01 : 2'b00;
                    state_n = S_DONE;
                end else if (fall) begin
                    tmr_n = BIT_LD;
                end
            end
            S_DONE: begin
                tmr_n   = '0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Moore outputs; pins are only ever pulled low or released.
    always_comb begin
        bus.tx_ready    = (state == S_IDLE) && ready_en;
        bus.busy        = (state != S_IDLE);
        bus.done        = (state == S_DONE);
        bus.error       = error_q;
        bus.ps2_clk_out = !((state == S_INHIBIT) || (state == S_REQ));
        bus.ps2_dat_out = 1'b1;
        if (state == S_REQ)
            bus.ps2_dat_out = 1'b0;
        else if (state == S_BITS)
            bus.ps2_dat_out = dat_reg;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    logic clk28 = 1'b0;
    logic rst   = 1'b1;
    logic dev_clk = 1'b1;
    logic dev_dat = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    ps2_host_tx_if bus ();

    // Wired-AND of the device and host open-drain drives.
    assign bus.ps2_clk_in = dev_clk & bus.ps2_clk_out;
    assign bus.ps2_dat_in = dev_dat & bus.ps2_dat_out;

    ps2_host_tx #(.FIRST_TIMEOUT_US(10)) dut (
        .clk28 (clk28),
        .rst   (rst),
        .bus   (bus)
    );

    always #18 clk28 = ~clk28;

    always @(posedge clk28) if (bus.done === 1'b1) done_cnt++;

    initial begin
        #(100000 * 36);
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] d, output int inh, output int req,
                             output int bad, output bit rel);
        inh = 0; req = 0; bad = 0;
        @(negedge clk28); bus.tx_data = d; bus.tx_valid = 1'b1;
        @(negedge clk28); bus.tx_valid = 1'b0; bus.tx_data = ~d;
        while (bus.ps2_clk_out === 1'b0 && bus.ps2_dat_out === 1'b1 && inh < 6000) begin
            if (bus.tx_ready !== 1'b0 || bus.busy !== 1'b1) bad++;
            inh++; @(negedge clk28);
        end
        while (bus.ps2_clk_out === 1'b0 && bus.ps2_dat_out === 1'b0 && req < 1000) begin
            if (bus.tx_ready !== 1'b0 || bus.busy !== 1'b1) bad++;
            req++; @(negedge clk28);
        end
        rel = (bus.ps2_clk_out === 1'b1);
    endtask

    task automatic device(input int half, input int n_edges, input bit ack, input int hold_low,
                          output logic [9:0] sampled, output int done_at_rel);
        sampled = '0; done_at_rel = done_cnt;
        repeat (100) @(negedge clk28);
        for (int k = 1; k <= n_edges; k++) begin
            if (k == 11 && ack) begin dev_dat = 1'b0; repeat (4) @(negedge clk28); end
            dev_clk = 1'b0;
            repeat (half + ((k == 11) ? hold_low : 0)) @(negedge clk28);
            if (k == 11) begin
                done_at_rel = done_cnt; dev_clk = 1'b1;
            end else if (k < n_edges) begin
                dev_clk = 1'b1; sampled[k-1] = bus.ps2_dat_in;
                repeat (half) @(negedge clk28);
            end
        end
        if (ack && n_edges == 11) begin repeat (half) @(negedge clk28); dev_dat = 1'b1; end
    endtask

    task automatic wait_done(input int limit, output bit got, output logic [1:0] err, output int cyc);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < limit) begin @(negedge clk28); cyc++; end
        got = (bus.done === 1'b1); err = bus.error;
    endtask

    task automatic test_reset();
        bus.tx_valid = 1'b0; bus.tx_data = 8'h00; rst = 1'b1;
        @(negedge clk28); @(negedge clk28);
        checks++; if (bus.ps2_clk_out !== 1'b1) begin errors++; $display("FAIL reset_clk_out got=%b exp=1", bus.ps2_clk_out); end
        checks++; if (bus.ps2_dat_out !== 1'b1) begin errors++; $display("FAIL reset_dat_out got=%b exp=1", bus.ps2_dat_out); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.error !== 2'b00) begin errors++; $display("FAIL reset_error got=%b exp=00", bus.error); end
        checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst got=%b exp=0", bus.tx_ready); end
        rst = 1'b0;
        @(negedge clk28);
        checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got=%b exp=1", bus.tx_ready); end
    endtask

    task automatic test_send_ed();
        int inh, req, bad, cyc, dr; bit rel, got; logic [1:0] err; logic [9:0] s;
        send_byte(8'hED, inh, req, bad, rel);
        checks++; if (inh !== 2800) begin errors++; $display("FAIL ed_inhibit_cycles got=%0d exp=2800", inh); end
        checks++; if (req !== 140) begin errors++; $display("FAIL ed_req_cycles got=%0d exp=140", req); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL ed_ready_busy_during_setup bad=%0d exp=0", bad); end
        checks++; if (rel !== 1'b1) begin errors++; $display("FAIL ed_clock_release got=%b exp=1", rel); end
        device(1400, 11, 1'b1, 0, s, dr);
        checks++; if (s !== 10'b11_1110_1101) begin errors++; $display("FAIL ed_frame got=%b exp=1111101101", s); end
        wait_done(3000, got, err, cyc);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL ed_done got=%b exp=1", got); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL ed_error got=%b exp=00", err); end
        @(negedge clk28);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL ed_done_width got=%b exp=0", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ed_busy_after got=%b exp=0", bus.busy); end
        checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL ed_ready_after got=%b exp=1", bus.tx_ready); end
    endtask

    task automatic test_parity();
        logic [7:0] dv [2]; logic [9:0] fv [2];
        int inh, req, bad, cyc, dr; bit rel, got; logic [1:0] err; logic [9:0] s;
        dv[0] = 8'h00; fv[0] = 10'b11_0000_0000;
        dv[1] = 8'h01; fv[1] = 10'b10_0000_0001;
        for (int i = 0; i < 2; i++) begin
            send_byte(dv[i], inh, req, bad, rel);
            checks++; if (bad !== 0) begin errors++; $display("FAIL parity_ready_low data=%h bad=%0d exp=0", dv[i], bad); end
            device(50, 11, 1'b1, 0, s, dr);
            checks++; if (s !== fv[i]) begin errors++; $display("FAIL parity_frame data=%h got=%b exp=%b", dv[i], s, fv[i]); end
            wait_done(2000, got, err, cyc);
            checks++; if (got !== 1'b1 || err !== 2'b00) begin errors++; $display("FAIL parity_done data=%h got=%b err=%b exp=1/00", dv[i], got, err); end
            checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL parity_ready_at_done got=%b exp=0", bus.tx_ready); end
            @(negedge clk28);
            checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL parity_ready_after got=%b exp=1", bus.tx_ready); end
        end
    endtask

    task automatic test_timeout();
        int inh, req, bad, cyc; bit rel, got; logic [1:0] err;
        send_byte(8'h3C, inh, req, bad, rel);
        checks++; if (bus.ps2_dat_out !== 1'b0) begin errors++; $display("FAIL timeout_start_bit got=%b exp=0", bus.ps2_dat_out); end
        wait_done(1000, got, err, cyc);
        checks++; if (cyc !== 280) begin errors++; $display("FAIL timeout_latency got=%0d exp=280", cyc); end
        checks++; if (got !== 1'b1 || err !== 2'b10) begin errors++; $display("FAIL timeout_error got=%b err=%b exp=1/10", got, err); end
        checks++; if (bus.ps2_clk_out !== 1'b1 || bus.ps2_dat_out !== 1'b1) begin errors++; $display("FAIL timeout_lines clk=%b dat=%b exp=1/1", bus.ps2_clk_out, bus.ps2_dat_out); end
        @(negedge clk28);
    endtask

    task automatic test_nack();
        int inh, req, bad, cyc, dr, base; bit rel, got; logic [1:0] err; logic [9:0] s;
        send_byte(8'h12, inh, req, bad, rel);
        base = done_cnt;
        device(50, 11, 1'b0, 200, s, dr);
        checks++; if (dr !== base) begin errors++; $display("FAIL nack_early_done got=%0d exp=%0d", dr - base, 0); end
        wait_done(2000, got, err, cyc);
        checks++; if (got !== 1'b1 || err !== 2'b01) begin errors++; $display("FAIL nack_error got=%b err=%b exp=1/01", got, err); end
        checks++; if (bus.ps2_clk_in !== 1'b1 || bus.ps2_dat_in !== 1'b1) begin errors++; $display("FAIL nack_lines clk=%b dat=%b exp=1/1", bus.ps2_clk_in, bus.ps2_dat_in); end
        @(negedge clk28);
    endtask

    task automatic test_reset_mid();
        int inh, req, bad, cyc, dr, base; bit rel, got; logic [1:0] err; logic [9:0] s;
        send_byte(8'hA5, inh, req, bad, rel);
        device(50, 5, 1'b0, 0, s, dr);
        checks++; if (bus.ps2_dat_out !== 1'b0) begin errors++; $display("FAIL rstmid_bit4 got=%b exp=0", bus.ps2_dat_out); end
        base = done_cnt;
        #3 rst = 1'b1;
        #1;
        checks++; if (bus.ps2_clk_out !== 1'b1 || bus.ps2_dat_out !== 1'b1) begin errors++; $display("FAIL rstmid_lines clk=%b dat=%b exp=1/1", bus.ps2_clk_out, bus.ps2_dat_out); end
        dev_clk = 1'b1;
        repeat (2) @(negedge clk28);
        rst = 1'b0;
        repeat (20) @(negedge clk28);
        checks++; if (done_cnt !== base) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=%0d", done_cnt, base); end
        checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", bus.tx_ready); end
        send_byte(8'hFF, inh, req, bad, rel);
        device(50, 11, 1'b1, 0, s, dr);
        checks++; if (s !== 10'b11_1111_1111) begin errors++; $display("FAIL rstmid_ff_frame got=%b exp=1111111111", s); end
        wait_done(2000, got, err, cyc);
        checks++; if (got !== 1'b1 || err !== 2'b00) begin errors++; $display("FAIL rstmid_ff_done got=%b err=%b exp=1/00", got, err); end
        @(negedge clk28);
    endtask

    task automatic test_ignored_valid();
        int inh, req, bad, cyc, dr, base, lows; bit rel, got; logic [1:0] err; logic [9:0] s;
        send_byte(8'hF3, inh, req, bad, rel);
        @(negedge clk28); bus.tx_data = 8'h55; bus.tx_valid = 1'b1;
        checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL ignore_ready got=%b exp=0", bus.tx_ready); end
        @(negedge clk28); bus.tx_valid = 1'b0;
        device(50, 11, 1'b1, 0, s, dr);
        checks++; if (s !== 10'b11_1111_0011) begin errors++; $display("FAIL ignore_frame got=%b exp=1111110011", s); end
        wait_done(2000, got, err, cyc);
        checks++; if (got !== 1'b1 || err !== 2'b00) begin errors++; $display("FAIL ignore_done got=%b err=%b exp=1/00", got, err); end
        @(negedge clk28);
        base = done_cnt; lows = 0;
        repeat (300) begin @(negedge clk28); if (bus.ps2_clk_out !== 1'b1) lows++; end
        checks++; if (lows !== 0 || done_cnt !== base) begin errors++; $display("FAIL ignore_no_resend low_cycles=%0d extra_done=%0d exp=0/0", lows, done_cnt - base); end
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_parity();
        test_timeout();
        test_nack();
        test_reset_mid();
        test_ignored_valid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
